// File: rtl/ltc2292_pkg.sv
// Shared types and constants for the LTC2292 ADC output emulator.
package ltc2292_pkg;

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned PAIR_W   = 2 * SAMPLE_W;

    typedef struct packed {
        logic [SAMPLE_W-1:0] a;
        logic [SAMPLE_W-1:0] b;
    } pair_t;

    // ph0/ph1: adc_clk_o high, ph2/ph3: adc_clk_o low
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);
    assign level = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ltc2292_tx.sv
// LTC2292 multiplexed-bus emulator: FIFO-fed sample pairs replayed A/B on a 4-phase ADC clock.
// Define LTC2292_TX_OFFSET_BIN_EN to emit offset binary instead of 2s complement.
module ltc2292_tx
    import ltc2292_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SAMPLE_W-1:0]       s_a,
    input  logic [SAMPLE_W-1:0]       s_b,
    output logic                      adc_clk_o,
    output logic [SAMPLE_W-1:0]       dout,
    output logic                      underrun,
    input  logic                      underrun_clr,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    function automatic logic [SAMPLE_W-1:0] out_code(input logic [SAMPLE_W-1:0] s);
`ifdef LTC2292_TX_OFFSET_BIN_EN
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
`else
        return s;
`endif
    endfunction

    phase_e              ph_q, ph_d;
    logic                adc_clk_q, adc_clk_d;
    pair_t               pipe_q [LATENCY];
    pair_t               pipe_d [LATENCY];
    pair_t               hold_q, hold_d;
    pair_t               in_pair;
    logic [SAMPLE_W-1:0] b_q, b_d;
    logic [SAMPLE_W-1:0] dout_q, dout_d;
    logic                underrun_q, underrun_d;
    logic [PAIR_W-1:0]   fifo_rdata;
    logic                fifo_empty, fifo_full, pop_slot;

    sync_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .wdata ({s_a, s_b}),
        .pop   (pop_slot),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign s_ready   = !fifo_full;
    assign adc_clk_o = adc_clk_q;
    assign dout      = dout_q;
    assign underrun  = underrun_q;

    always_comb begin
        pop_slot   = en && (ph_q == PH0);
        ph_d       = en ? phase_e'(ph_q + 2'd1) : PH3;
        adc_clk_d  = en && ((ph_d == PH0) || (ph_d == PH1));
        hold_d     = hold_q;
        b_d        = b_q;
        dout_d     = dout_q;
        pipe_d     = pipe_q;
        in_pair    = fifo_empty ? hold_q : pair_t'(fifo_rdata);
        underrun_d = underrun_q;
        if (pop_slot && fifo_empty) underrun_d = 1'b1;
        else if (underrun_clr)      underrun_d = 1'b0;
        // The oldest stage is captured whole at ph0 so B survives the pipeline shift.
        if (pop_slot) begin
            hold_d    = in_pair;
            pipe_d[0] = in_pair;
            for (int unsigned i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
            dout_d = out_code(pipe_q[LATENCY-1].a);
            b_d    = pipe_q[LATENCY-1].b;
        end
        if (en && (ph_q == PH2)) dout_d = out_code(b_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q       <= PH3;
            adc_clk_q  <= 1'b0;
            for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            hold_q     <= '0;
            b_q        <= '0;
            dout_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            adc_clk_q  <= adc_clk_d;
            pipe_q     <= pipe_d;
            hold_q     <= hold_d;
            b_q        <= b_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_ltc2292_tx.sv
// Directed self-checking bench for ltc2292_tx (DEPTH=4, LATENCY=5).
module tb_ltc2292_tx;

`ifdef LTC2292_TX_OFFSET_BIN_EN
    localparam logic [11:0] MASK = 12'h800;
`else
    localparam logic [11:0] MASK = 12'h000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_a = '0;
    logic [11:0] s_b = '0;
    logic        adc_clk_o;
    logic [11:0] dout;
    logic        underrun;
    logic        underrun_clr = 1'b0;
    logic [2:0]  fifo_level;

    int unsigned checks = 0;
    int unsigned failures = 0;

    ltc2292_tx #(.DEPTH(4), .LATENCY(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .adc_clk_o    (adc_clk_o),
        .dout         (dout),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_pair(input logic [11:0] a, input logic [11:0] b);
        bit done = 0;
        s_a = a; s_b = b; s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (s_ready) begin
                @(negedge clk);
                done = 1;
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL push_timeout: s_ready=%0b required 1", s_ready);
        end
    endtask

    // Returns raw dout at the next adc_clk_o fall (A) and following rise (B).
    task automatic get_pair(output logic [11:0] a, output logic [11:0] b, output bit ok);
        logic prev, have;
        ok = 0; have = 0; a = '0; b = '0;
        prev = adc_clk_o;
        for (int i = 0; i < 48 && !ok; i++) begin
            @(negedge clk);
            if (prev && !adc_clk_o) begin a = dout; have = 1; end
            else if (!prev && adc_clk_o && have) begin b = dout; ok = 1; end
            prev = adc_clk_o;
        end
    endtask

    task automatic next_nz_pair(output logic [11:0] a, output logic [11:0] b, output bit ok);
        ok = 0; a = '0; b = '0;
        for (int i = 0; i < 12; i++) begin
            get_pair(a, b, ok);
            if (!ok) break;
            if ((a ^ MASK) != 12'h000) break;
            ok = 0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (dout !== 12'h000) begin failures++; $display("FAIL reset_dout: got %h want 000", dout); end
        checks++; if (adc_clk_o !== 1'b0) begin failures++; $display("FAIL reset_adc_clk: got %b want 0", adc_clk_o); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", s_ready); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency;
        int cnt;
        bit seen;
        logic early_nonzero;
        do_reset;
        push_pair(12'h123, 12'hEDC);
        en = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_level == 3'd0) begin seen = 1; break; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL latency_pop: level=%0d want 0", fifo_level); end
        cnt = 0; early_nonzero = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if ((dout ^ MASK) == 12'h123) break;
            if ((dout ^ MASK) != 12'h000) early_nonzero = 1;
        end
        checks++; if (cnt != 20) begin failures++; $display("FAIL latency_clks: got %0d want 20", cnt); end
        checks++; if (early_nonzero !== 1'b0) begin failures++; $display("FAIL latency_early: got %b want 0", early_nonzero); end
        checks++; if (adc_clk_o !== 1'b1) begin failures++; $display("FAIL latency_ph1_clk: got %b want 1", adc_clk_o); end
        @(negedge clk);
        checks++; if (adc_clk_o !== 1'b0 || (dout ^ MASK) !== 12'h123) begin
            failures++; $display("FAIL latency_fall_a: clk=%b dout=%h want clk=0 A=123", adc_clk_o, dout ^ MASK); end
        @(negedge clk);
        checks++; if (adc_clk_o !== 1'b0 || (dout ^ MASK) !== 12'hEDC) begin
            failures++; $display("FAIL latency_ph3_b: clk=%b dout=%h want clk=0 B=edc", adc_clk_o, dout ^ MASK); end
        @(negedge clk);
        checks++; if (adc_clk_o !== 1'b1 || (dout ^ MASK) !== 12'hEDC) begin
            failures++; $display("FAIL latency_rise_b: clk=%b dout=%h want clk=1 B=edc", adc_clk_o, dout ^ MASK); end
    endtask

    task automatic test_fill;
        logic [11:0] ea [4] = '{12'h101, 12'h202, 12'h303, 12'h404};
        logic [11:0] eb [4] = '{12'hA01, 12'hB02, 12'hC03, 12'hD04};
        logic [11:0] a, b;
        bit ok;
        do_reset;
        for (int i = 0; i < 4; i++) push_pair(ea[i], eb[i]);
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fill_level: got %0d want 4", fifo_level); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b want 0", s_ready); end
        s_a = 12'h555; s_b = 12'h555; s_valid = 1'b1;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fill_fifth: level=%0d want 4", fifo_level); end
        en = 1'b1;
        next_nz_pair(a, b, ok);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) get_pair(a, b, ok);
            checks++;
            if (!ok || (a ^ MASK) !== ea[i] || (b ^ MASK) !== eb[i]) begin
                failures++;
                $display("FAIL fill_order[%0d]: got %h/%h ok=%0b want %h/%h", i, a ^ MASK, b ^ MASK, ok, ea[i], eb[i]);
            end
        end
    endtask

    task automatic test_underrun;
        logic [11:0] a, b;
        bit ok, found;
        logic prev;
        do_reset;
        en = 1'b1;
        push_pair(12'h7FF, 12'h800);
        next_nz_pair(a, b, ok);
        checks++; if (!ok || (a ^ MASK) !== 12'h7FF || (b ^ MASK) !== 12'h800) begin
            failures++; $display("FAIL starve_first: got %h/%h want 7ff/800", a ^ MASK, b ^ MASK); end
        for (int i = 0; i < 2; i++) begin
            get_pair(a, b, ok);
            checks++; if (!ok || (a ^ MASK) !== 12'h7FF || (b ^ MASK) !== 12'h800) begin
                failures++; $display("FAIL starve_repeat[%0d]: got %h/%h want 7ff/800", i, a ^ MASK, b ^ MASK); end
        end
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_set: got %b want 1", underrun); end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_clr_starve: got %b want 1", underrun); end
        // Hold clr across a pop edge while still starved
        prev = adc_clk_o; found = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!prev && adc_clk_o) begin found = 1; break; end
            prev = adc_clk_o;
        end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        checks++; if (!found || underrun !== 1'b1) begin
            failures++; $display("FAIL underrun_priority: got %b found=%0b want 1", underrun, found); end
        push_pair(12'h111, 12'h222);
        found = 0;
        for (int i = 0; i < 8; i++) begin
            if (fifo_level == 3'd0) begin found = 1; break; end
            @(negedge clk);
        end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        checks++; if (!found || underrun !== 1'b0) begin
            failures++; $display("FAIL underrun_cleared: got %b found=%0b want 0", underrun, found); end
    endtask

    task automatic test_en_hold;
        logic [11:0] d0;
        logic [2:0]  lvl;
        en = 1'b0;
        @(negedge clk);
        checks++; if (adc_clk_o !== 1'b0) begin failures++; $display("FAIL hold_clk_low: got %b want 0", adc_clk_o); end
        d0 = dout; lvl = fifo_level;
        push_pair(12'h333, 12'h444);
        repeat (6) @(negedge clk);
        checks++; if (dout !== d0) begin failures++; $display("FAIL hold_dout: got %h want %h", dout, d0); end
        checks++; if (fifo_level !== lvl + 3'd1) begin failures++; $display("FAIL hold_push: level=%0d want %0d", fifo_level, lvl + 3'd1); end
        en = 1'b1;
        @(negedge clk);
        checks++; if (adc_clk_o !== 1'b1) begin failures++; $display("FAIL en_rise_ph0: got %b want 1", adc_clk_o); end
    endtask

    task automatic test_offset;
        logic [11:0] a, b;
        bit ok;
        do_reset;
        push_pair(12'h555, 12'h555);
        push_pair(12'h000, 12'h800);
        en = 1'b1;
        next_nz_pair(a, b, ok);
        checks++; if (!ok || (a ^ MASK) !== 12'h555) begin failures++; $display("FAIL offset_marker: got %h want 555", a ^ MASK); end
        get_pair(a, b, ok);
        checks++; if (!ok || a !== (12'h000 ^ MASK)) begin failures++; $display("FAIL offset_a: got %h want %h", a, 12'h000 ^ MASK); end
        checks++; if (!ok || b !== (12'h800 ^ MASK)) begin failures++; $display("FAIL offset_b: got %h want %h", b, 12'h800 ^ MASK); end
    endtask

    task automatic test_mid_reset;
        logic [11:0] a, b;
        bit ok, found;
        logic prev;
        do_reset;
        en = 1'b1;
        push_pair(12'hA01, 12'hA11);
        push_pair(12'hA02, 12'hA12);
        next_nz_pair(a, b, ok);
        push_pair(12'hB01, 12'hB11);
        push_pair(12'hB02, 12'hB12);
        prev = adc_clk_o; found = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (prev && !adc_clk_o) begin found = 1; break; end
            prev = adc_clk_o;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (!found || dout !== 12'h000) begin failures++; $display("FAIL midrst_dout: got %h want 000", dout); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL midrst_level: got %0d want 0", fifo_level); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_pair(12'hC01, 12'hC02);
        next_nz_pair(a, b, ok);
        checks++; if (!ok || (a ^ MASK) !== 12'hC01 || (b ^ MASK) !== 12'hC02) begin
            failures++; $display("FAIL midrst_new: got %h/%h want c01/c02", a ^ MASK, b ^ MASK); end
    endtask

    task automatic test_back_to_back;
        int unsigned push_idx = 0, exp_idx = 0, cyc = 0, last_acc = 0, gaps = 0;
        bit full_seen = 0, have_last = 0, have_a = 0;
        logic prev;
        logic [11:0] ca, ra, rb, ea, eb;
        do_reset;
        en = 1'b1;
        prev = adc_clk_o;
        while (exp_idx < 1000 && cyc < 6000) begin
            if (prev && !adc_clk_o) begin ca = dout; have_a = 1; end
            else if (!prev && adc_clk_o && have_a) begin
                ra = ca ^ MASK; rb = dout ^ MASK; have_a = 0;
                if (ra != 12'h000) begin
                    ea = 12'(exp_idx + 1); eb = ~ea;
                    checks++;
                    if (ra !== ea || rb !== eb) begin
                        failures++; $display("FAIL stream_pair[%0d]: got %h/%h want %h/%h", exp_idx, ra, rb, ea, eb);
                    end
                    exp_idx++;
                end
            end
            prev = adc_clk_o;
            s_valid = (push_idx < 1000);
            s_a = 12'(push_idx + 1); s_b = ~s_a;
            if (!s_ready) full_seen = 1;
            if (s_valid && s_ready) begin
                if (full_seen) begin
                    if (have_last) begin
                        gaps++; checks++;
                        if (cyc - last_acc != 4) begin
                            failures++; $display("FAIL stream_gap: got %0d want 4", cyc - last_acc);
                        end
                    end
                    have_last = 1; last_acc = cyc;
                end
                push_idx++;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (exp_idx != 1000) begin failures++; $display("FAIL stream_count: got %0d want 1000", exp_idx); end
        checks++; if (gaps < 900) begin failures++; $display("FAIL stream_gaps_seen: got %0d want >=900", gaps); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_fill;
        test_underrun;
        test_en_hold;
        test_offset;
        test_mid_reset;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
